priority_encoder: RTL and testbench
===================================

# priority_encoder

Parameterised priority encoder that converts a 2^OUT_WIDTH-bit match vector into the binary index of its lowest-numbered set bit. It sits behind the TLB's per-entry comparators, where it turns the `matched` vector into the entry index used for lookups. It also reports whether any bit matched and whether several bits matched at once, which flags a duplicate TLB entry. Results are available combinationally for the lookup path and as a registered copy for pipelined consumers.

## Interface
- `OUT_WIDTH`, default 3: index width; input vector width is N = 2^OUT_WIDTH; legal range 1..6.
- `clk`  input  1  clock; all registers update on its rising edge.
- `res`  input  1  reset, asynchronous, active-low; asserting it (0) clears all registered outputs immediately.
- `en`  input  1  capture enable for the registered outputs.
- `in`  input  N  match vector; bit i set means entry i matched.
- `out`  output  OUT_WIDTH  combinational index of the lowest set bit of `in`.
- `found`  output  1  combinational; OR-reduction of `in`.
- `multi`  output  1  combinational; 1 when two or more bits of `in` are set.
- `out_q`  output  OUT_WIDTH  registered `out`.
- `found_q`  output  1  registered `found`.
- `multi_q`  output  1  registered `multi`.

## Operation
- Priority: the lowest index wins. `out` = min{i : in[i] = 1}.
- When `in` is all zeros: `out` = 0 and `found` = 0. Consumers must qualify `out` with `found`.
- `multi` = `found` AND (`in` with its lowest set bit cleared ≠ 0). Equivalently, `multi` is 1 when at least two bits of `in` are set.
- `out`, `found` and `multi` are purely combinational. They have no dependency on `clk`, `res` or `en`, and contain no latches.
- Implementation is structural and width-generic, for example a log2 tree of 2:1 priority merges. The result must be identical to a linear lowest-index scan for every OUT_WIDTH.
- Outputs are never X for any fully-defined `in`.

## Timing
- Combinational outputs: zero-cycle latency from `in`.
- Registered outputs: when `en` = 1 at a rising edge of `clk`, `out_q`/`found_q`/`multi_q` take the combinational values present at that edge. This gives 1-cycle latency.
- When `en` = 0, the registered outputs hold their values.
- Reset: while `res` = 0, `out_q` = 0, `found_q` = 0 and `multi_q` = 0, asynchronously and regardless of `clk` or `en`.
- Reset removal: the first capture happens at the first rising edge with `res` = 1 and `en` = 1.
- Reset asserted in mid-operation overrides any capture in the same cycle.
- Combinational outputs are unaffected by reset.

## Test plan
All scenarios use OUT_WIDTH = 3.
- `in` = 8'b0000_0000 -> `out` = 0, `found` = 0, `multi` = 0.
- Walking one-hot: `in` = 1<<k for k = 0..7 -> `out` = k, `found` = 1, `multi` = 0.
- Multiple bits set:
  - `in` = 8'b1010_0100 -> `out` = 2, `found` = 1, `multi` = 1.
  - `in` = 8'b1000_0001 -> `out` = 0, `multi` = 1.
  - `in` = 8'hFF -> `out` = 0, `multi` = 1.
- Registered path:
  - With `res` = 1, `en` = 1 and `in` = 8'b0100_0000, one clock edge -> `out_q` = 6, `found_q` = 1, `multi_q` = 0.
  - Then drop `en` and change `in` to 0 -> registered outputs hold 6/1/0.
- Reset: drive `res` = 0 between clock edges -> `out_q`/`found_q`/`multi_q` go to 0 immediately. While `res` stays 0, an edge with `en` = 1 and `in` = 8'hFF leaves them at 0.
- Exhaustive: all 256 values of `in`, compared against a reference linear scan for `out`, `found` and `multi`. Repeat for OUT_WIDTH = 1 and 5, with random `in` for width 5.

Source files
------------

// File: rtl/priority_encoder.sv
// Lowest-index priority encoder for the TLB match vector: a log2 tree of
// 2:1 priority merges gives index/found/multi, plus a registered copy.

module priority_encoder_node #(
  parameter int IW_I = 1,
  parameter int IW_O = 1
) (
  input  logic            i_va,
  input  logic            i_vb,
  input  logic            i_ma,
  input  logic            i_mb,
  input  logic [IW_I-1:0] i_ia,
  input  logic [IW_I-1:0] i_ib,
  output logic            o_v,
  output logic            o_m,
  output logic [IW_O-1:0] o_idx
);
  logic [IW_O-1:0] w_hi;

  always_comb begin
    w_hi = '0;
    w_hi[IW_O-1] = 1'b1;
  end

  assign o_v = i_va | i_vb;
  // Two valid halves means at least two set bits, regardless of either half's own multi.
  assign o_m = i_ma | i_mb | (i_va & i_vb);
  assign o_idx = i_va ? IW_O'(i_ia)
               : i_vb ? (IW_O'(i_ib) | w_hi)
               : '0;
endmodule

module priority_encoder #(
  parameter int OUT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     en,
  input  logic [(1<<OUT_WIDTH)-1:0] in,
  output logic [OUT_WIDTH-1:0]     out,
  output logic                     found,
  output logic                     multi,
  output logic [OUT_WIDTH-1:0]     out_q,
  output logic                     found_q,
  output logic                     multi_q
);
  localparam int N = 1 << OUT_WIDTH;

  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_found;
  logic                 r_multi;

  // Level l holds N>>l nodes, each summarising a 2^l-bit slice of in.
  for (genvar l = 0; l <= OUT_WIDTH; l++) begin : g_lvl
    localparam int NN = N >> l;
    localparam int IW = (l > 0) ? l : 1;
    logic [NN-1:0]         w_v;
    logic [NN-1:0]         w_m;
    logic [NN-1:0][IW-1:0] w_idx;

    if (l == 0) begin : g_leaf
      assign w_v   = in;
      assign w_m   = '0;
      assign w_idx = '0;
    end else begin : g_merge
      for (genvar j = 0; j < NN; j++) begin : g_node
        priority_encoder_node #(
          .IW_I ((l > 1) ? l - 1 : 1),
          .IW_O (IW)
        ) u_node (
          .i_va  (g_lvl[l-1].w_v[2*j]),
          .i_vb  (g_lvl[l-1].w_v[2*j+1]),
          .i_ma  (g_lvl[l-1].w_m[2*j]),
          .i_mb  (g_lvl[l-1].w_m[2*j+1]),
          .i_ia  (g_lvl[l-1].w_idx[2*j]),
          .i_ib  (g_lvl[l-1].w_idx[2*j+1]),
          .o_v   (w_v[j]),
          .o_m   (w_m[j]),
          .o_idx (w_idx[j])
        );
      end
    end
  end

  assign out   = g_lvl[OUT_WIDTH].w_idx[0];
  assign found = g_lvl[OUT_WIDTH].w_v[0];
  assign multi = g_lvl[OUT_WIDTH].w_m[0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_out   <= '0;
      r_found <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_out   <= out;
      r_found <= found;
      r_multi <= multi;
    end
  end

  assign out_q   = r_out;
  assign found_q = r_found;
  assign multi_q = r_multi;
endmodule

// File: tb/tb_priority_encoder.sv
// Directed + randomized bench for priority_encoder at OUT_WIDTH 3, 1 and 5,
// checked against a linear-scan / popcount reference.

module tb_priority_encoder;
  logic clk = 1'b0;
  logic res, en;
  logic [7:0]  in3;
  logic [1:0]  in1;
  logic [31:0] in5;

  logic [2:0] out3, out3_q;
  logic       found3, multi3, found3_q, multi3_q;
  logic [0:0] out1, out1_q;
  logic       found1, multi1, found1_q, multi1_q;
  logic [4:0] out5, out5_q;
  logic       found5, multi5, found5_q, multi5_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  priority_encoder #(.OUT_WIDTH(3)) u_dut3 (
    .clk(clk), .res(res), .en(en), .in(in3),
    .out(out3), .found(found3), .multi(multi3),
    .out_q(out3_q), .found_q(found3_q), .multi_q(multi3_q)
  );
  priority_encoder #(.OUT_WIDTH(1)) u_dut1 (
    .clk(clk), .res(res), .en(en), .in(in1),
    .out(out1), .found(found1), .multi(multi1),
    .out_q(out1_q), .found_q(found1_q), .multi_q(multi1_q)
  );
  priority_encoder #(.OUT_WIDTH(5)) u_dut5 (
    .clk(clk), .res(res), .en(en), .in(in5),
    .out(out5), .found(found5), .multi(multi5),
    .out_q(out5_q), .found_q(found5_q), .multi_q(multi5_q)
  );

  function automatic int ref_idx(logic [63:0] v, int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(string tag, logic [7:0] v);
    chk({tag, ".out"},   64'(out3),   64'(ref_idx(64'(v), 8)));
    chk({tag, ".found"}, 64'(found3), 64'(v != 0));
    chk({tag, ".multi"}, 64'(multi3), 64'($countones(v) >= 2));
  endtask

  task automatic chk_q(string tag, int e_out, bit e_found, bit e_multi);
    chk({tag, ".out_q"},   64'(out3_q),   64'(e_out));
    chk({tag, ".found_q"}, 64'(found3_q), 64'(e_found));
    chk({tag, ".multi_q"}, 64'(multi3_q), 64'(e_multi));
  endtask

  initial begin
    logic [7:0]  v8;
    logic [31:0] v32;
    int   e_out;
    bit   e_found, e_multi;

    res = 1'b0; en = 1'b0; in3 = '0; in1 = '0; in5 = '0;
    #3;
    chk_q("reset_state", 0, 1'b0, 1'b0);

    // Combinational checks run while in reset: reset must not touch them.
    in3 = 8'h00; #1;
    chk("zero.out", 64'(out3), 64'd0);
    chk("zero.found", 64'(found3), 64'd0);
    chk("zero.multi", 64'(multi3), 64'd0);

    for (int k = 0; k < 8; k++) begin
      in3 = 8'(1 << k); #1;
      chk("onehot.out", 64'(out3), 64'(k));
      chk("onehot.found", 64'(found3), 64'd1);
      chk("onehot.multi", 64'(multi3), 64'd0);
    end

    in3 = 8'b1010_0100; #1;
    chk("a4.out", 64'(out3), 64'd2);
    chk("a4.found", 64'(found3), 64'd1);
    chk("a4.multi", 64'(multi3), 64'd1);
    in3 = 8'b1000_0001; #1;
    chk("81.out", 64'(out3), 64'd0);
    chk("81.multi", 64'(multi3), 64'd1);
    in3 = 8'hFF; #1;
    chk("ff.out", 64'(out3), 64'd0);
    chk("ff.multi", 64'(multi3), 64'd1);

    for (int v = 0; v < 256; v++) begin
      in3 = 8'(v); #1;
      chk3("exh3", in3);
    end

    for (int v = 0; v < 4; v++) begin
      in1 = 2'(v); #1;
      chk("w1.out", 64'(out1), 64'(ref_idx(64'(in1), 2)));
      chk("w1.found", 64'(found1), 64'(in1 != 0));
      chk("w1.multi", 64'(multi1), 64'($countones(in1) >= 2));
    end

    for (int t = 0; t < 300; t++) begin
      // Mix dense, sparse and one-hot vectors so high indices get exercised.
      case (t % 3)
        0: v32 = $urandom;
        1: v32 = $urandom & $urandom & $urandom & $urandom;
        default: v32 = 32'(1) << $urandom_range(31, 0);
      endcase
      in5 = v32; #1;
      chk("w5.out", 64'(out5), 64'(ref_idx(64'(in5), 32)));
      chk("w5.found", 64'(found5), 64'(in5 != 0));
      chk("w5.multi", 64'(multi5), 64'($countones(in5) >= 2));
    end

    // Registered path.
    @(negedge clk);
    res = 1'b1; en = 1'b1; in3 = 8'b0100_0000;
    @(posedge clk); #1;
    chk_q("cap40", 6, 1'b1, 1'b0);
    @(negedge clk);
    en = 1'b0; in3 = 8'h00;
    @(posedge clk); #1;
    chk_q("hold", 6, 1'b1, 1'b0);

    e_out = 6; e_found = 1'b1; e_multi = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      en = 1'($urandom);
      v8 = 8'($urandom);
      in3 = v8;
      if (en) begin
        e_out = ref_idx(64'(v8), 8);
        e_found = (v8 != 0);
        e_multi = ($countones(v8) >= 2);
      end
      @(posedge clk); #1;
      chk_q("rand_q", e_out, e_found, e_multi);
    end

    // Asynchronous reset between edges, then reset overriding a capture.
    @(negedge clk);
    en = 1'b1; in3 = 8'b0010_1000;
    @(posedge clk); #1;
    chk_q("pre_rst", 3, 1'b1, 1'b1);
    #2 res = 1'b0; #1;
    chk_q("async_rst", 0, 1'b0, 1'b0);
    in3 = 8'hFF; en = 1'b1;
    @(posedge clk); #1;
    chk_q("rst_hold", 0, 1'b0, 1'b0);
    chk("rst_comb.found", 64'(found3), 64'd1);
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    chk_q("post_rst", 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
